// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM states, default operand width.
package alu_pkg;

   localparam int WIDTH = 3;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the ALU and its client (operand source / display mux).
interface alu_seq_if import alu_pkg::*; ();

   logic                 Start;
   logic [1:0]           Op;
   logic [WIDTH-1:0]     PortA;
   logic [WIDTH-1:0]     PortB;
   logic [2*WIDTH-1:0]   Result;
   logic                 Busy;
   logic                 Done;
   logic                 Error;

   modport master (
      output Start, Op, PortA, PortB,
      input  Result, Busy, Done, Error
   );

   modport slave (
      input  Start, Op, PortA, PortB,
      output Result, Busy, Done, Error
   );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative unit: shift-add multiply (multiplier LSB first) and restoring divide.
// One iteration per cycle for W cycles; valid_o and result_o present the value of
// the final iteration combinationally so the caller can register it on that edge.
module alu_muldiv import alu_pkg::*; #(
   parameter int W = WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [2*W-1:0]   result_o
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic             active_q, active_d;
   logic             is_div_q, is_div_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*W-1:0]   acc_q, acc_d;      // multiply partial product
   logic [2*W-1:0]   mcand_q, mcand_d;  // multiplicand, shifted left each step
   logic [W-1:0]     shreg_q, shreg_d;  // multiplier (mul) or dividend -> quotient (div)
   logic [W-1:0]     rem_q, rem_d;
   logic [W-1:0]     divisor_q, divisor_d;

   logic [W:0]       shifted_s;
   logic [W:0]       diff_s;
   logic             valid_s;
   logic [2*W-1:0]   step_result_s;

   // Iteration datapath: load on start, otherwise advance one mul or div step.
   always_comb begin
      active_d      = active_q;
      is_div_d      = is_div_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      mcand_d       = mcand_q;
      shreg_d       = shreg_q;
      rem_d         = rem_q;
      divisor_d     = divisor_q;
      valid_s       = 1'b0;
      step_result_s = '0;

      shifted_s = {rem_q, shreg_q[W-1]};
      diff_s    = shifted_s - {1'b0, divisor_q};

      if (start_i) begin
         active_d  = 1'b1;
         is_div_d  = (op_i == OP_DIV);
         cnt_d     = '0;
         acc_d     = '0;
         mcand_d   = {{W{1'b0}}, a_i};
         shreg_d   = (op_i == OP_DIV) ? a_i : b_i;
         rem_d     = '0;
         divisor_d = b_i;
      end else if (active_q) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
         if (is_div_q) begin
            // Borrow out of the trial subtraction means "restore" (quotient bit 0).
            if (diff_s[W]) begin
               rem_d   = shifted_s[W-1:0];
               shreg_d = {shreg_q[W-2:0], 1'b0};
            end else begin
               rem_d   = diff_s[W-1:0];
               shreg_d = {shreg_q[W-2:0], 1'b1};
            end
            step_result_s = {rem_d, shreg_d};
         end else begin
            acc_d         = acc_q + (shreg_q[0] ? mcand_q : {(2*W){1'b0}});
            mcand_d       = mcand_q << 1;
            shreg_d       = shreg_q >> 1;
            step_result_s = acc_d;
         end
         if (cnt_q == LAST) begin
            active_d = 1'b0;
            valid_s  = 1'b1;
         end else begin
            active_d = 1'b1;
         end
      end else begin
         active_d = 1'b0;
      end
   end

   // Iteration state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q  <= 1'b0;
         is_div_q  <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         shreg_q   <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
      end else begin
         active_q  <= active_d;
         is_div_q  <= is_div_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         shreg_q   <= shreg_d;
         rem_q     <= rem_d;
         divisor_q <= divisor_d;
      end
   end

   assign busy_o   = active_q;
   assign valid_o  = valid_s;
   assign result_o = step_result_s;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: Start edge detect, IDLE/EXEC FSM, add/sub, registered outputs.
module alu_seq import alu_pkg::*; (
   input logic        ClockA,
   input logic        Reset,
   alu_seq_if.slave   bus
);

   localparam int W = WIDTH;

   logic             start_q;
   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [2*W-1:0]   result_q, result_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             trig_s;
   logic             md_start_s;
   logic             md_busy_s;
   logic             md_valid_s;
   logic [2*W-1:0]   md_result_s;

   assign trig_s = bus.Start & ~start_q;

   alu_muldiv #(.W(W)) u_muldiv (
      .clk_i    (ClockA),
      .rst_i    (Reset),
      .start_i  (md_start_s),
      .op_i     (bus.Op),
      .a_i      (bus.PortA),
      .b_i      (bus.PortB),
      .busy_o   (md_busy_s),
      .valid_o  (md_valid_s),
      .result_o (md_result_s)
   );

   // Next-state and output-register values; completion writes Result/Done/Error together.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      result_d   = result_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = error_q;
      md_start_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (trig_s) begin
               a_d        = bus.PortA;
               b_d        = bus.PortB;
               op_d       = bus.Op;
               busy_d     = 1'b1;
               state_d    = ST_EXEC;
               // Divide by zero never enters the iterative unit.
               md_start_s = (bus.Op == OP_MUL) ||
                            ((bus.Op == OP_DIV) && (bus.PortB != {W{1'b0}}));
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            case (op_q)
               OP_ADD: begin
                  result_d = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
                  error_d  = 1'b0;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  state_d  = ST_IDLE;
               end
               OP_SUB: begin
                  result_d = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
                  error_d  = 1'b0;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  state_d  = ST_IDLE;
               end
               default: begin
                  if ((op_q == OP_DIV) && (b_q == {W{1'b0}})) begin
                     result_d = {(2*W){1'b1}};
                     error_d  = 1'b1;
                     done_d   = 1'b1;
                     busy_d   = 1'b0;
                     state_d  = ST_IDLE;
                  end else if (md_valid_s) begin
                     result_d = md_result_s;
                     error_d  = 1'b0;
                     done_d   = 1'b1;
                     busy_d   = 1'b0;
                     state_d  = ST_IDLE;
                  end else if (!md_busy_s) begin
                     // Unit idle without delivering: drop the request, keep the old result.
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_EXEC;
                  end
               end
            endcase
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched operands, edge-detect history and output registers.
   always_ff @(posedge ClockA) begin
      if (Reset) begin
         start_q  <= 1'b0;
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         start_q  <= bus.Start;
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign bus.Result = result_q;
   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;
   assign bus.Error  = error_q;

endmodule
